// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the shared-stack arbiter.
// Exports the FSM state enum, the op encoding and the default sizing.
package stack_arb_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_DEPTH     = 32;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stack_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
// Produces a one-hot grant and the matching index (both zero when nobody requests).
module rr_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int IDX_W     = idx_width(DEF_NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0] cand_s;
    logic             any_s;

    // Scan from the farthest candidate back to rr_ptr so the nearest one is written last.
    always_comb begin
        any_s     = |req;
        cand_s    = {IDX_W{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            cand_s    = IDX_W'((int'(rr_ptr) + i) % NUM_CORES);
            grant_idx = req[cand_s] ? cand_s : grant_idx;
        end
        grant = any_s ? (NUM_CORES'(1) << grant_idx) : {NUM_CORES{1'b0}};
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack among NUM_CORES requesters.
// Optional macro STACK_ARB_OCC_EN exposes the shadow count as occ/full/empty.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        op,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [NUM_CORES-1:0]        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        stk_push,
    output logic                        stk_pop,
    output logic [DATA_W-1:0]           stk_datain,
    input  logic [DATA_W-1:0]           stk_dataout
`ifdef STACK_ARB_OCC_EN
    ,
    output logic [$clog2(DEPTH):0]      occ,
    output logic                        full,
    output logic                        empty
`endif
);

    localparam int               IDX_W   = idx_width(NUM_CORES);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    arb_state_e           state_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     grant_idx_r;
    logic [NUM_CORES-1:0] grant_oh_r;
    logic                 op_r;
    logic                 err_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;

    logic [IDX_W-1:0]     pick_idx_s;
    logic [NUM_CORES-1:0] pick_oh_s;
    logic                 sel_op_s;
    logic [DATA_W-1:0]    sel_wdata_s;
    logic                 can_push_s;
    logic                 can_pop_s;
    logic [IDX_W-1:0]     ptr_nxt_s;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr_r),
        .grant     (pick_oh_s),
        .grant_idx (pick_idx_s)
    );

    // Shadow occupancy: only a successful ISSUE moves the count, so it cannot leave 0..DEPTH.
    always_comb begin
        count_nxt_s = count_r;
        if ((state_r == ISSUE) && !err_r) begin
            if (op_r == OP_PUSH) begin
                count_nxt_s = count_r + CNT_W'(1);
            end else begin
                count_nxt_s = count_r - CNT_W'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

`ifdef STACK_ARB_OCC_EN
    logic full_r;
    logic empty_r;

    // Status flags follow the count in the same edge it updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign occ   = count_r;
    assign full  = full_r;
    assign empty = empty_r;

    // Registered flags are exact mirrors of the count, so the range checks reuse them.
    always_comb begin
        can_push_s = !full_r;
        can_pop_s  = !empty_r;
    end
`else
    // Range checks straight from the count register.
    always_comb begin
        can_push_s = (count_r < DEPTH_C);
        can_pop_s  = (count_r != {CNT_W{1'b0}});
    end
`endif

    // Grantee operands and the pointer value that follows the current grantee.
    always_comb begin
        sel_op_s    = op[pick_idx_s];
        sel_wdata_s = wdata[int'(pick_idx_s)*DATA_W +: DATA_W];
        ptr_nxt_s   = (grant_idx_r == IDX_W'(NUM_CORES - 1)) ? {IDX_W{1'b0}}
                                                              : grant_idx_r + IDX_W'(1);
    end

    // Main IDLE -> ISSUE -> RESP sequencer; strobes are set on entry to ISSUE so they last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IDX_W{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            grant_oh_r  <= {NUM_CORES{1'b0}};
            op_r        <= OP_POP;
            err_r       <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            ack         <= {NUM_CORES{1'b0}};
            err         <= {NUM_CORES{1'b0}};
            rdata       <= {DATA_W{1'b0}};
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_datain  <= {DATA_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            case (state_r)
                IDLE: begin
                    ack   <= {NUM_CORES{1'b0}};
                    err   <= {NUM_CORES{1'b0}};
                    rdata <= {DATA_W{1'b0}};
                    if (|req) begin
                        grant_idx_r <= pick_idx_s;
                        grant_oh_r  <= pick_oh_s;
                        op_r        <= sel_op_s;
                        if ((sel_op_s == OP_PUSH) && can_push_s) begin
                            stk_push   <= 1'b1;
                            stk_datain <= sel_wdata_s;
                            err_r      <= 1'b0;
                        end else if ((sel_op_s == OP_POP) && can_pop_s) begin
                            stk_pop    <= 1'b1;
                            err_r      <= 1'b0;
                        end else begin
                            err_r      <= 1'b1;
                        end
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    stk_push   <= 1'b0;
                    stk_pop    <= 1'b0;
                    stk_datain <= {DATA_W{1'b0}};
                    ack        <= grant_oh_r;
                    err        <= err_r ? grant_oh_r : {NUM_CORES{1'b0}};
                    // The stack's dataout still shows the popped word at this edge.
                    rdata      <= ((op_r == OP_POP) && !err_r) ? stk_dataout : {DATA_W{1'b0}};
                    state_r    <= RESP;
                end
                RESP: begin
                    ack      <= {NUM_CORES{1'b0}};
                    err      <= {NUM_CORES{1'b0}};
                    rdata    <= {DATA_W{1'b0}};
                    rr_ptr_r <= ptr_nxt_s;
                    state_r  <= IDLE;
                end
                default: begin
                    ack        <= {NUM_CORES{1'b0}};
                    err        <= {NUM_CORES{1'b0}};
                    rdata      <= {DATA_W{1'b0}};
                    stk_push   <= 1'b0;
                    stk_pop    <= 1'b0;
                    stk_datain <= {DATA_W{1'b0}};
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: LIFO-queue reference model plus a behavioural stack.
// Build with +define+STACK_ARB_OCC_EN to also check occ/full/empty.
module tb_stack_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [15:0] rdata;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_datain;
    logic [15:0] stk_dataout;
`ifdef STACK_ARB_OCC_EN
    logic [5:0]  occ;
    logic        full;
    logic        empty;
`endif

    int          tests;
    int          fails;
    int          ref_ptr;
    logic [15:0] ref_q[$];
    logic [15:0] last_rdata;
    logic        last_err;

    // Behavioural 32-entry stack with a combinational top-of-stack output.
    logic [15:0] stk_mem [0:31];
    logic [6:0]  sp;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 7'd0;
        end else if (stk_push) begin
            if (sp < 7'd32) stk_mem[5'(sp)] <= stk_datain;
            sp <= sp + 7'd1;
        end else if (stk_pop) begin
            sp <= sp - 7'd1;
        end
    end

    assign stk_dataout = ((sp != 7'd0) && (sp <= 7'd32)) ? stk_mem[5'(sp - 7'd1)] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stack_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op          (op),
        .wdata       (wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .stk_datain  (stk_datain),
        .stk_dataout (stk_dataout)
`ifdef STACK_ARB_OCC_EN
        ,
        .occ         (occ),
        .full        (full),
        .empty       (empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    task automatic check_status();
`ifdef STACK_ARB_OCC_EN
        chk("occ", 32'(occ), ref_q.size());
        chk("full", 32'(full), 32'(ref_q.size() == 32));
        chk("empty", 32'(empty), 32'(ref_q.size() == 0));
`else
        chk("stack_depth_status", 32'(sp), ref_q.size());
`endif
    endtask

    // Raise the given requests and follow every acknowledge against the model.
    task automatic run_ops(input logic [3:0] mask, input logic [3:0] ops, input logic [63:0] wd);
        logic [3:0]  pend;
        logic [3:0]  exp_ack;
        logic [15:0] din_seen;
        logic [15:0] exp_rd;
        logic [15:0] data_g;
        logic        exp_err;
        logic        push_seen;
        logic        pop_seen;
        logic        ok;
        int          since;
        int          budget;
        int          g;
        bit          first;
        @(negedge clk);
        req = mask; op = ops; wdata = wd;
        pend = mask; since = 0; budget = 0; first = 1'b1;
        push_seen = 1'b0; pop_seen = 1'b0; din_seen = 16'h0000;
        while ((pend != 4'b0000) && (budget < 40)) begin
            @(negedge clk);
            budget++; since++;
            ok = !(stk_push && stk_pop) && ($countones(ack) <= 1) &&
                 (stk_push || (stk_datain == 16'h0000)) && ((err & ~ack) == 4'b0000) &&
                 ((ack != 4'b0000) || (rdata == 16'h0000));
            chk("invariant", 32'(ok), 32'd1);
            if (stk_push) begin push_seen = 1'b1; din_seen = stk_datain; end
            if (stk_pop) pop_seen = 1'b1;
            if (ack != 4'b0000) begin
                g       = pick(pend, ref_ptr);
                exp_ack = 4'b0001 << g;
                data_g  = wd[g*16 +: 16];
                if (ops[g]) begin
                    exp_err = (ref_q.size() >= 32);
                    exp_rd  = 16'h0000;
                    if (!exp_err) ref_q.push_back(data_g);
                end else begin
                    exp_err = (ref_q.size() == 0);
                    exp_rd  = exp_err ? 16'h0000 : ref_q.pop_back();
                end
                chk("ack", 32'(ack), 32'(exp_ack));
                chk("err", 32'(err), exp_err ? 32'(exp_ack) : 32'd0);
                chk("rdata", 32'(rdata), 32'(exp_rd));
                chk("latency", since, first ? 2 : 3);
                chk("push_strobe", 32'(push_seen), 32'(ops[g] && !exp_err));
                chk("pop_strobe", 32'(pop_seen), 32'(!ops[g] && !exp_err));
                if (push_seen) chk("datain", 32'(din_seen), 32'(data_g));
                chk("stack_depth", 32'(sp), ref_q.size());
                check_status();
                last_rdata = rdata;
                last_err   = err[g];
                ref_ptr    = (g + 1) % 4;
                pend[g]    = 1'b0;
                req[g]     = 1'b0;
                since = 0; first = 1'b0; push_seen = 1'b0; pop_seen = 1'b0;
            end
        end
        chk("timeout_pending", 32'(pend), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        chk("rst_datain", 32'(stk_datain), 32'd0);
`ifdef STACK_ARB_OCC_EN
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
`endif
        rst = 1'b0;
        ref_q.delete();
        ref_ptr = 0;
    endtask

    initial begin
        logic [3:0]  m;
        logic [15:0] exp32;
        int          acks;
        bit          found;
        tests = 0; fails = 0; ref_ptr = 0;
        last_rdata = 16'h0000; last_err = 1'b0;
        rst = 1'b1; req = 4'b0000; op = 4'b0000; wdata = 64'h0;
        repeat (2) @(negedge clk);
        apply_reset();

        // Core 2 push then pop of BEEF.
        run_ops(4'b0100, 4'b0100, 64'h0000_BEEF_0000_0000);
        run_ops(4'b0100, 4'b0000, 64'h0);
        chk("beef_rdata", 32'(last_rdata), 32'h0000_BEEF);
        chk("beef_err", 32'(last_err), 32'd0);
        chk("beef_depth", 32'(sp), 32'd0);

        // All four cores at once, pushes then pops.
        run_ops(4'hF, 4'hF, {$urandom, $urandom});
        run_ops(4'hF, 4'h0, 64'h0);

        // Pop on empty from core 1.
        run_ops(4'b0010, 4'b0000, 64'h0);
        chk("empty_pop_err", 32'(last_err), 32'd1);
        chk("empty_pop_rdata", 32'(last_rdata), 32'd0);

        // Fill to capacity, overflow, then pop the last stored word.
        for (int k = 0; k < 32; k++) begin
            m = 4'b0001 << (k % 4);
            run_ops(m, 4'hF, {$urandom, $urandom});
        end
        exp32 = ref_q[31];
        run_ops(4'b0001, 4'hF, {$urandom, $urandom});
        chk("overflow_err", 32'(last_err), 32'd1);
        run_ops(4'b0010, 4'h0, 64'h0);
        chk("full_pop_rdata", 32'(last_rdata), 32'(exp32));
        chk("full_pop_depth", 32'(sp), 32'd31);

        // Reset during the ISSUE cycle of a push.
        @(negedge clk);
        req = 4'b0100; op = 4'b0100; wdata = 64'h0000_5A5A_0000_0000;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (stk_push) found = 1'b1;
        end
        chk("rst_issue_seen", 32'(found), 32'd1);
        rst = 1'b1; req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_issue_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
        ref_q.delete();
        ref_ptr = 0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack != 4'b0000) acks++;
        end
        chk("rst_issue_no_ack", acks, 0);
        run_ops(4'b1001, 4'b1001, {$urandom, $urandom});
        run_ops(4'b0001, 4'b0000, 64'h0);

        // Three pushes then reset (occupancy flags checked at each ack).
        apply_reset();
        run_ops(4'b0111, 4'b0111, {$urandom, $urandom});
        chk("three_push_depth", 32'(sp), 32'd3);
        apply_reset();

        // Randomised traffic: push-heavy first half, pop-heavy second half.
        for (int it = 0; it < 100; it++) begin
            m = 4'($urandom_range(1, 15));
            if (it < 50) run_ops(m, 4'($urandom | $urandom), {$urandom, $urandom});
            else         run_ops(m, 4'($urandom & $urandom), {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

- Shares one 16-bit, 32-entry LIFO stack among the four cores of the parallel processor.
- Serialises their push/pop requests with round-robin arbitration and drives the stack's push/pop/datain strobes for one cycle per operation.
- Captures pop data and returns it with a one-cycle acknowledge.
- Keeps a shadow occupancy count, because the stack exposes no full or empty status; out-of-range operations are blocked rather than issued.

## Interface
- NUM_CORES, 4: number of requesters.
- DATA_W, 16: stack word width.
- DEPTH, 32: stack capacity in entries; the count register is $clog2(DEPTH)+1 bits wide.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CORES  per-core request; held high until that core's ack.
- op  in  NUM_CORES  per-core operation: 1 = push, 0 = pop; stable while req is high.
- wdata  in  NUM_CORES*DATA_W  per-core push data; core i occupies slice [i*DATA_W +: DATA_W]; stable while req is high.
- ack  out  NUM_CORES  one-cycle completion pulse, one-hot.
- err  out  NUM_CORES  one-cycle error flag, coincident with ack: push when full, or pop when empty.
- rdata  out  DATA_W  pop result; valid while ack is high, 0 otherwise.
- stk_push  out  1  drives the stack's push input.
- stk_pop  out  1  drives the stack's pop input.
- stk_datain  out  DATA_W  drives the stack's datain.
- stk_dataout  in  DATA_W  stack's combinational dataout.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any req is high, the round-robin picker selects the first requester at or after the pointer `rr_ptr`.
  - Registers the grantee index, its op and its wdata, then moves to ISSUE.
  - With no req high, stays in IDLE.
- **ISSUE** (exactly one cycle)
  - Push with count < DEPTH: stk_push=1, stk_datain = latched wdata; count increments by 1.
  - Pop with count > 0: stk_pop=1; stk_dataout is captured into the rdata register at this edge; count decrements by 1.
  - Push with count == DEPTH, or pop with count == 0: no strobe is issued, an error bit is latched, and rdata is latched as 0.
  - Always moves to RESP.
- **RESP** (exactly one cycle)
  - ack[grantee]=1, err[grantee] = latched error bit, rdata driven.
  - rr_ptr becomes (grantee+1) mod NUM_CORES.
  - Moves to IDLE.
- **Requester rule:** a core drops req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- **Mutual exclusion:** stk_push and stk_pop are never high together, and only in ISSUE. At most one ack bit is high in any cycle.
- **Count range:** saturates by construction, 0..DEPTH; no wrap-around.
- **rst:** forces IDLE, count=0, rr_ptr=0, and all outputs to 0.
  - rst has priority over an in-flight ISSUE/RESP; the pending op is dropped with no ack.
  - The stack's pointer has no reset, so rst is applied only together with stack re-initialisation (power-up or full system reset).

## Timing
- Latency: req sampled at edge N (IDLE) → strobe during cycle N+1 (ISSUE) → ack during cycle N+2 (RESP).
- Throughput: one operation per 3 cycles.
- Fairness: with all cores requesting continuously, grants go 0,1,2,3,0,…; each core waits at most NUM_CORES operations.
- stk_datain is 0 whenever stk_push is low.

## Configuration
- Macro `STACK_ARB_OCC_EN`.
- **Defined:** adds outputs `occ` (count width, the current count), `full` (count==DEPTH) and `empty` (count==0), all registered and reset to 0/0/1.
- **Undefined:** these ports are absent. The internal count and err behaviour are unchanged.

## Structure
- Shared package `stack_arb_pkg`:
  - state enum {IDLE, ISSUE, RESP};
  - OP_PUSH/OP_POP constants;
  - default DEPTH/DATA_W localparams.
- Sub-module `rr_arbiter`: combinational round-robin picker (inputs req and rr_ptr; outputs one-hot grant and index), parameterised by NUM_CORES.

## Test plan
- Core 2 pushes 16'hBEEF, then pops → stk_push in cycle 1 with datain BEEF; second op's ack[2] with rdata=BEEF, err=0; count returns to 0.
- All four cores request with rr_ptr=0 → acks in order 0,1,2,3, each 3 cycles apart; no strobe overlap.
- Pop on empty from core 1 → no stk_pop pulse, ack[1]=1, err[1]=1, rdata=0, count stays 0.
- 32 pushes, then a 33rd push → 33rd gets err=1, no stk_push; a following pop returns the 32nd value, count 31.
- rst asserted during ISSUE of a push → next cycle state IDLE, no ack, count=0, rr_ptr=0; a new request completes normally.
- With STACK_ARB_OCC_EN defined: after 3 pushes, occ=3, full=0, empty=0; after reset, empty=1.
